// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 decryption core.
// Includes the forward S-box (key expansion), the inverse S-box and Rcon.
package aes_inv_pkg;

  typedef enum logic [1:0] {StIdle, StKeyExp, StRound} aes_inv_state_e;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b;
      8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b;
      8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d;
      8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf;
      8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26;
      8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1;
      8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3;
      8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2;
      8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a;
      8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3;
      8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed;
      8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39;
      8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb;
      8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f;
      8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f;
      8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21;
      8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec;
      8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d;
      8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc;
      8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14;
      8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a;
      8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62;
      8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d;
      8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea;
      8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e;
      8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f;
      8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66;
      8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9;
      8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11;
      8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9;
      8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d;
      8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f;
      8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5;
      8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e;
      8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82;
      8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44;
      8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32;
      8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b;
      8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66;
      8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49;
      8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64;
      8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc;
      8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50;
      8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57;
      8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00;
      8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05;
      8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f;
      8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03;
      8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41;
      8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce;
      8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22;
      8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8;
      8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71;
      8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e;
      8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b;
      8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe;
      8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33;
      8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59;
      8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9;
      8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f;
      8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d;
      8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c;
      8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e;
      8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63;
      8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    unique case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless final_i is set, InvMixColumns.
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [127:0] sub_bytes;
  logic [127:0] ark;
  logic [127:0] mixed;

  always_comb begin
    sub_bytes = '0;
    mixed     = '0;
    // Byte 4*c+r sits at row r, column c; row r is rotated right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_bytes[127 - 8*(4*c + r) -: 8] =
            inv_sbox(state_i[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    ark = sub_bytes ^ rk_i;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 8] = gf_mul(ark[127 - 32*c -: 8], 8'h0e) ^
                               gf_mul(ark[119 - 32*c -: 8], 8'h0b) ^
                               gf_mul(ark[111 - 32*c -: 8], 8'h0d) ^
                               gf_mul(ark[103 - 32*c -: 8], 8'h09);
      mixed[119 - 32*c -: 8] = gf_mul(ark[127 - 32*c -: 8], 8'h09) ^
                               gf_mul(ark[119 - 32*c -: 8], 8'h0e) ^
                               gf_mul(ark[111 - 32*c -: 8], 8'h0b) ^
                               gf_mul(ark[103 - 32*c -: 8], 8'h0d);
      mixed[111 - 32*c -: 8] = gf_mul(ark[127 - 32*c -: 8], 8'h0d) ^
                               gf_mul(ark[119 - 32*c -: 8], 8'h09) ^
                               gf_mul(ark[111 - 32*c -: 8], 8'h0e) ^
                               gf_mul(ark[103 - 32*c -: 8], 8'h0b);
      mixed[103 - 32*c -: 8] = gf_mul(ark[127 - 32*c -: 8], 8'h0b) ^
                               gf_mul(ark[119 - 32*c -: 8], 8'h0d) ^
                               gf_mul(ark[111 - 32*c -: 8], 8'h09) ^
                               gf_mul(ark[103 - 32*c -: 8], 8'h0e);
    end
    state_o = final_i ? ark : mixed;
  end

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryption: ten forward key-expansion cycles to reach rk10,
// then ten inverse rounds with the round key regenerated backwards each cycle.
module aes_inv_top
  import aes_inv_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_dec_en,
  input  logic [127:0] AES_dec_data_in,
  input  logic [127:0] AES_dec_key_in,
  output logic [127:0] AES_dec_data_out,
  output logic         AES_dec_data_out_valid,
  output logic         AES_dec_busy
);

  aes_inv_state_e fsm_q, fsm_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   out_q, out_d;
  logic           valid_q, valid_d;

  logic [31:0]    fwd_t, f0, f1, f2, f3;
  logic [31:0]    b0, b1, b2, b3;
  logic [127:0]   key_fwd, key_bwd, round_out;
  logic           round_final;

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // Forward step rk(cnt-1) -> rk(cnt).
  assign fwd_t   = sub_rot_word(key_q[31:0], rcon(cnt_q));
  assign f0      = key_q[127:96] ^ fwd_t;
  assign f1      = key_q[95:64] ^ f0;
  assign f2      = key_q[63:32] ^ f1;
  assign f3      = key_q[31:0] ^ f2;
  assign key_fwd = {f0, f1, f2, f3};

  // Backward step rk(cnt+1) -> rk(cnt); the last three words must be undone first.
  assign b3      = key_q[31:0] ^ key_q[63:32];
  assign b2      = key_q[63:32] ^ key_q[95:64];
  assign b1      = key_q[95:64] ^ key_q[127:96];
  assign b0      = key_q[127:96] ^ sub_rot_word(b3, rcon(cnt_q + 4'd1));
  assign key_bwd = {b0, b1, b2, b3};

  assign round_final = (cnt_q == 4'd0);

  aes_inv_round u_round (
    .state_i (state_q),
    .rk_i    (key_bwd),
    .final_i (round_final),
    .state_o (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = out_q;
    valid_d = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (AES_dec_en) begin
          state_d = AES_dec_data_in;
          key_d   = AES_dec_key_in;
          cnt_d   = 4'd1;
          fsm_d   = StKeyExp;
        end
      end
      StKeyExp: begin
        key_d = key_fwd;
        if (cnt_q == 4'd10) begin
          state_d = state_q ^ key_fwd;
          cnt_d   = 4'd9;
          fsm_d   = StRound;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRound: begin
        key_d   = key_bwd;
        state_d = round_out;
        if (round_final) begin
          out_d   = round_out;
          valid_d = 1'b1;
          fsm_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      fsm_q   <= StIdle;
      cnt_q   <= 4'd0;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign AES_dec_data_out       = out_q;
  assign AES_dec_data_out_valid = valid_q;
  assign AES_dec_busy           = (fsm_q != StIdle);

endmodule

// File: tb/tb_aes_inv_top.sv
// Directed bench for aes_inv_top: FIPS-197 vectors, busy/back-to-back/reset corners,
// and a loopback against a small behavioural AES-128 encryptor.
module tb_aes_inv_top;
  import aes_inv_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] din;
  logic [127:0] kin;
  logic [127:0] dout;
  logic         dout_valid;
  logic         busy;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t tbl [3];

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_top dut (
    .AES_clk                (clk),
    .AES_rst_n              (rst_n),
    .AES_dec_en             (en),
    .AES_dec_data_in        (din),
    .AES_dec_key_in         (kin),
    .AES_dec_data_out       (dout),
    .AES_dec_data_out_valid (dout_valid),
    .AES_dec_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Reference forward cipher, used only to build the loopback ciphertext.
  function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k, t;
    logic [31:0]  w;
    logic [7:0]   rc, a0, a1, a2, a3;
    s  = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w = k[31:0];
      w = {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
      k[127:96] = k[127:96] ^ w;
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0] ^ k[63:32];
      rc = xt(rc);
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          t[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        end
      end
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 32*c -: 8];
          a1 = t[119 - 32*c -: 8];
          a2 = t[111 - 32*c -: 8];
          a3 = t[103 - 32*c -: 8];
          t[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = t ^ k;
    end
    return s;
  endfunction

  // One full operation; with disturb set, a junk request is raised at E5.
  task automatic run_op(input string nm, input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] pt, input bit disturb);
    int lat;
    bit busy_ok;
    en  = 1'b1;
    din = ct;
    kin = key;
    tick();
    en  = 1'b0;
    din = ~ct;
    kin = ~key;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      en = disturb && (i == 5);
      if (en) din = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      tick();
      if (dout_valid) lat = i;
      else if (!busy) busy_ok = 1'b0;
    end
    en = 1'b0;
    chk({nm, " latency"}, 128'(lat), 128'd20);
    chk({nm, " data"}, dout, pt);
    chk({nm, " busy during op"}, 128'(busy_ok), 128'd1);
    chk({nm, " busy at done"}, 128'(busy), 128'd0);
    tick();
    chk({nm, " valid falls"}, 128'(dout_valid), 128'd0);
    chk({nm, " data held"}, dout, pt);
  endtask

  initial begin
    int v1, v2;
    logic [127:0] out1, out2, out40;
    logic busy21;
    bit seen;
    logic [127:0] lb_key, lb_pt, lb_ct;

    n_vec = 0;
    n_err = 0;
    tbl[0] = '{key: C1Key, ct: C1Ct, pt: C1Pt};
    tbl[1] = '{key: BKey, ct: BCt, pt: BPt};
    tbl[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: 128'h0};

    rst_n = 1'b0;
    en    = 1'b0;
    din   = '0;
    kin   = '0;
    tick();
    tick();
    chk("reset data", dout, 128'h0);
    chk("reset valid", 128'(dout_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].key, tbl[i].ct, tbl[i].pt, 1'b0);
    end

    run_op("busy ignore", C1Key, C1Ct, C1Pt, 1'b1);

    // Back-to-back: App. B first, C.1 accepted at E21.
    en  = 1'b1;
    din = BCt;
    kin = BKey;
    tick();
    din = C1Ct;
    kin = C1Key;
    v1 = 0;
    v2 = 0;
    out1 = '0;
    out2 = '0;
    out40 = '0;
    busy21 = 1'b0;
    for (int i = 1; i <= 60 && v2 == 0; i++) begin
      tick();
      if (i == 21) begin
        en = 1'b0;
        busy21 = busy;
      end
      if (i == 40) out40 = dout;
      if (dout_valid) begin
        if (v1 == 0) begin
          v1 = i;
          out1 = dout;
        end else begin
          v2 = i;
          out2 = dout;
        end
      end
    end
    en = 1'b0;
    chk("b2b first latency", 128'(v1), 128'd20);
    chk("b2b first data", out1, BPt);
    chk("b2b accepted at E21", 128'(busy21), 128'd1);
    chk("b2b hold before second", out40, BPt);
    chk("b2b second valid edge", 128'(v2), 128'd41);
    chk("b2b second data", out2, C1Pt);
    tick();

    // Reset at E12 mid-operation.
    en  = 1'b1;
    din = C1Ct;
    kin = C1Key;
    tick();
    en = 1'b0;
    repeat (11) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset data", dout, 128'h0);
    chk("midreset valid", 128'(dout_valid), 128'd0);
    chk("midreset busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (dout_valid) seen = 1'b1;
    end
    chk("midreset no valid pulse", 128'(seen), 128'd0);
    run_op("after reset", C1Key, C1Ct, C1Pt, 1'b0);

    // Reset coinciding with a request drops the request.
    rst_n = 1'b0;
    en    = 1'b1;
    tick();
    rst_n = 1'b1;
    en    = 1'b0;
    tick();
    chk("reset beats en", 128'(busy), 128'd0);

    lb_key = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
    lb_pt  = 128'h000000cd000000000000000000000000;
    lb_ct  = enc_model(lb_pt, lb_key);
    run_op("loopback", lb_key, lb_ct, lb_pt, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_top.md
# aes_inv_top

Iterative AES-128 decryption core, the inverse counterpart of the AES_top encryption block. It accepts a 128-bit ciphertext and the original 128-bit cipher key, and runs the forward key expansion to obtain the last round key. It then performs ten inverse rounds, one per clock, regenerating round keys backwards on the fly. It shares AES_top's clocking, reset and valid-pulse conventions so the two can be chained for loopback checks.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- AES_clk  input  1  single clock, all logic on rising edge.
- AES_rst_n  input  1  reset; synchronous, active-low.
- AES_dec_en  input  1  start request; sampled only in IDLE.
- AES_dec_data_in  input  128  ciphertext; byte 0 = bits [127:120], column-major per FIPS-197.
- AES_dec_key_in  input  128  original cipher key (round key 0), same byte order.
- AES_dec_data_out  output  128  recovered plaintext; held until the next result.
- AES_dec_data_out_valid  output  1  one-cycle pulse when AES_dec_data_out is updated.
- AES_dec_busy  output  1  high while an operation is in progress.

## Operation
- States: IDLE, KEYEXP, ROUND, then back to IDLE. A 4-bit counter `cnt` is used in KEYEXP and ROUND.
- IDLE: if AES_dec_en=1 at an edge (E0):
  - latch ciphertext and key;
  - set cnt=1;
  - go to KEYEXP.
- KEYEXP, edges E1..E10: the key register advances forward from rk(cnt-1) to rk(cnt) using Rcon[cnt].
  - At E10 the state register also loads ciphertext XOR rk10, with rk10 taken combinationally.
  - Then cnt=9 and the FSM goes to ROUND.
- ROUND, edges E11..E20: the key register steps backward from rk(cnt+1) to rk(cnt) via the inverse key schedule:
  - w[i-4] = w[i] XOR f(w[i-1]) for the first word;
  - w[i-4] = w[i] XOR w[i-1] otherwise;
  - Rcon index is cnt+1.
- ROUND datapath, combinational rk(cnt) into the state:
  - cnt=9..1: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - cnt=0: InvShiftRows, InvSubBytes, AddRoundKey, with no InvMixColumns.
  - At E20 the result goes to AES_dec_data_out, valid=1, busy=0, and the FSM returns to IDLE.
- AES_dec_en while busy is ignored. Inputs are not re-sampled mid-operation.
- Reset (AES_rst_n=0 at an edge), including mid-operation, does all of the following:
  - FSM to IDLE, cnt=0;
  - state, key and output registers cleared to 0;
  - valid=0, busy=0.
  - Any operation in flight is abandoned with no valid pulse.
- Arithmetic:
  - GF(2^8) uses polynomial 0x11B.
  - InvMixColumns coefficients are {0e,0b,0d,09}.
  - All XORs are 128-bit, with no carries.

## Timing
- Reset values of all outputs are 0.
- Latency: valid and data are visible after edge E20, i.e. 20 cycles after the accepting edge E0.
- Busy is high after E0 through before E20 (20 cycles).
- Valid is high for exactly one cycle. It falls at E21 unconditionally.
- Back-to-back: if AES_dec_en stays high, the next operation is accepted at E21, giving one block per 21 cycles.
  - The new result overwrites AES_dec_data_out only at its own completion.
- Simultaneous reset and AES_dec_en: reset wins and the request is dropped.
- Inputs may change after E0 without affecting the result.
- The critical path is one inverse round plus one inverse key-schedule step. This must meet the same clock as AES_top.

## Structure
- Package aes_inv_pkg holds:
  - FSM state enum;
  - forward sbox and inv_sbox functions (256-entry case);
  - Rcon function (index 1..10);
  - xtime and gf_mul helpers.
- Sub-module aes_inv_round is purely combinational.
  - Inputs: state, round key, final flag.
  - Output: next state.
  - Instantiated once.
- The key-schedule forward/backward step stays inline in aes_inv_top.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out 00112233445566778899aabbccddeeff, with valid exactly 20 cycles after E0.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Required: out 3243f6a8885a308d313198a2e0370734.
- Zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Required: out all-zero, with the valid pulse present (distinguishes it from the reset value).
- Busy handling: pulse AES_dec_en again and change data_in at E5.
  - Required: ignored, with the C.1 result unchanged.
  - Then hold en high across two blocks: second accepted at E21, second valid at E41.
- Reset at E12 mid-operation.
  - Required: all outputs 0 next cycle, no valid pulse.
  - A new C.1 request after reset completes correctly.
- Loopback: AES_top encrypts pt 000000cd000000000000000000000000 under key aa2bdb40bff6a5e8caa9ba3ebc1e2acc; its output feeds aes_inv_top with the same key.
  - Required: the original plaintext is recovered.
